// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-side and result signals between a command source, the sequencer and the ALU.
// master = sequencer side, slave = environment (command source, ALU, result consumer).
interface alu_cmd_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 16,
    parameter int FLAG_W = 4,
    parameter int CNT_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_c;
    logic [FLAG_W-1:0] alu_flags;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_c;
    logic [FLAG_W-1:0] res_flags;
    logic [CNT_W-1:0]  ops_done;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, alu_flags, res_ready,
        output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_c, res_flags, ops_done, busy
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, alu_flags, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_c, res_flags, ops_done, busy
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Drives one ALU operation at a time: accept command, hold ALU inputs, wait the
// ALU latency, capture c/flags and return them over a valid/ready result port.
module alu_cmd_sequencer #(
    parameter int DATA_W      = 16,
    parameter int OP_W        = 16,
    parameter int FLAG_W      = 4,
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic reset,
    alu_cmd_sequencer_if.master bus
);
    // Wait counter only needs to hold ALU_LATENCY; keep at least one bit for the combinational case.
    localparam int CW = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [DATA_W-1:0] res_c_q;
    logic [FLAG_W-1:0] res_flags_q;
    logic [CNT_W-1:0]  ops_done_q;

    // Qualified with reset so ready is low for the whole reset window, not just after the first edge.
    assign bus.cmd_ready = (state == ST_IDLE) && reset;
    assign bus.res_valid = (state == ST_DONE);
    assign bus.busy      = (state == ST_WAIT) || (state == ST_DONE);
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.res_c     = res_c_q;
    assign bus.res_flags = res_flags_q;
    assign bus.ops_done  = ops_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_c_q     <= '0;
            res_flags_q <= '0;
            ops_done_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        alu_a_q  <= bus.cmd_a;
                        alu_b_q  <= bus.cmd_b;
                        alu_op_q <= bus.cmd_op;
                        cnt      <= CW'(ALU_LATENCY);
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Capture one edge after cnt reaches zero: edge N + ALU_LATENCY + 1.
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        res_c_q     <= bus.alu_c;
                        res_flags_q <= bus.alu_flags;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        ops_done_q <= ops_done_q + CNT_W'(1);
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A stalled result must not move while the consumer is not ready.
    a_res_stable: assert property (@(posedge clk) disable iff (!reset)
        (state == ST_DONE && !bus.res_ready) |=> (state == ST_DONE && $stable(res_c_q) && $stable(res_flags_q)));

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: latency-1 instance (u0) and combinational-ALU, 4-bit-counter instance (u1),
// each with a behavioural ALU model; expected results are queued at command acceptance.
module tb_alu_cmd_sequencer;
    logic clk = 0;
    logic reset0 = 1;
    logic reset1 = 1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [19:0] q0[$];
    logic [19:0] q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer_if #(.DATA_W(16), .OP_W(16), .FLAG_W(4), .CNT_W(16)) i0 ();
    alu_cmd_sequencer_if #(.DATA_W(16), .OP_W(16), .FLAG_W(4), .CNT_W(4))  i1 ();

    alu_cmd_sequencer #(.DATA_W(16), .OP_W(16), .FLAG_W(4), .ALU_LATENCY(1), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset0), .bus(i0.master));
    alu_cmd_sequencer #(.DATA_W(16), .OP_W(16), .FLAG_W(4), .ALU_LATENCY(0), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset1), .bus(i1.master));

    // ALU model: {flags[3:0], c[15:0]}, flags = {overflow, negative, zero, carry}.
    function automatic logic [19:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [15:0] op);
        logic [16:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            16'd0: begin r = {1'b0, a} + {1'b0, b}; v = (a[15] == b[15]) && (r[15] != a[15]); end
            16'd1: begin r = {1'b0, a} - {1'b0, b}; v = (a[15] != b[15]) && (r[15] != a[15]); end
            16'd2: r = {1'b0, a & b};
            16'd3: r = {1'b0, a | b};
            default: r = {1'b0, a ^ b};
        endcase
        return {v, r[15], (r[15:0] == 16'h0), r[16], r[15:0]};
    endfunction

    always @(posedge clk) {i0.alu_flags, i0.alu_c} <= alu_fn(i0.alu_a, i0.alu_b, i0.alu_op);
    assign {i1.alu_flags, i1.alu_c} = alu_fn(i1.alu_a, i1.alu_b, i1.alu_op);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command on u0 until accepted; queue its expected result at the accept edge.
    task automatic send0(input logic [15:0] a, input logic [15:0] b, input logic [15:0] op,
                         output bit ok, output int acc);
        ok = 0;
        acc = 0;
        i0.cmd_a = a; i0.cmd_b = b; i0.cmd_op = op; i0.cmd_valid = 1'b1;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (i0.cmd_ready) begin
                step();
                ok = 1;
                acc = cyc;
                q0.push_back(alu_fn(a, b, op));
            end else begin
                step();
            end
        end
        i0.cmd_valid = 1'b0;
    endtask

    task automatic wait_res0(output bit ok, output int rcyc);
        ok = 0;
        rcyc = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (i0.res_valid) begin ok = 1; rcyc = cyc; end
            else step();
        end
    endtask

    task automatic test_reset();
        i0.cmd_valid = 0; i0.cmd_a = 0; i0.cmd_b = 0; i0.cmd_op = 0; i0.res_ready = 0;
        i1.cmd_valid = 0; i1.cmd_a = 0; i1.cmd_b = 0; i1.cmd_op = 0; i1.res_ready = 0;
        #2;
        reset0 = 0;
        reset1 = 0;
        step();
        step();
        n_chk++; if (i0.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready0: got %b want 0", i0.cmd_ready); end
        n_chk++; if (i1.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready1: got %b want 0", i1.cmd_ready); end
        n_chk++; if ({i0.alu_a, i0.alu_b, i0.alu_op} !== 48'h0) begin n_fail++; $display("FAIL rst_alu_in: got %h want 0", {i0.alu_a, i0.alu_b, i0.alu_op}); end
        n_chk++; if ({i0.res_valid, i0.busy} !== 2'b00) begin n_fail++; $display("FAIL rst_valid_busy: got %b want 00", {i0.res_valid, i0.busy}); end
        n_chk++; if ({i0.res_flags, i0.res_c} !== 20'h0) begin n_fail++; $display("FAIL rst_res: got %h want 0", {i0.res_flags, i0.res_c}); end
        n_chk++; if (i0.ops_done !== 16'h0) begin n_fail++; $display("FAIL rst_ops_done: got %h want 0", i0.ops_done); end
        reset0 = 1;
        reset1 = 1;
        step();
        n_chk++; if (i0.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rel_cmd_ready0: got %b want 1", i0.cmd_ready); end
        n_chk++; if (i1.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rel_cmd_ready1: got %b want 1", i1.cmd_ready); end
    endtask

    task automatic test_single();
        bit ok;
        int acc, rcyc;
        logic [19:0] e;
        send0(16'h00FF, 16'h0001, 16'h0000, ok, acc);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL t2_accept: got timeout want accept"); end
        n_chk++; if (i0.alu_a !== 16'h00FF || i0.alu_b !== 16'h0001) begin n_fail++; $display("FAIL t2_alu_in: got %h/%h want 00ff/0001", i0.alu_a, i0.alu_b); end
        n_chk++; if ({i0.busy, i0.cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL t2_busy: got %b want 10", {i0.busy, i0.cmd_ready}); end
        wait_res0(ok, rcyc);
        n_chk++; if (!ok || rcyc - acc != 2) begin n_fail++; $display("FAIL t2_latency: got %0d want 2", rcyc - acc); end
        e = q0.pop_front();
        n_chk++; if ({i0.res_flags, i0.res_c} !== e) begin n_fail++; $display("FAIL t2_scoreboard: got %h want %h", {i0.res_flags, i0.res_c}, e); end
        n_chk++; if (i0.res_c !== 16'h0100 || i0.res_flags !== 4'b0000) begin n_fail++; $display("FAIL t2_res: got %h/%b want 0100/0000", i0.res_c, i0.res_flags); end
        i0.res_ready = 1;
        step();
        i0.res_ready = 0;
        n_chk++; if (i0.ops_done !== 16'd1) begin n_fail++; $display("FAIL t2_ops_done: got %0d want 1", i0.ops_done); end
        n_chk++; if ({i0.res_valid, i0.cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL t2_idle: got %b want 01", {i0.res_valid, i0.cmd_ready}); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int acc, rcyc;
        logic [19:0] e;
        send0(16'h1234, 16'h0F0F, 16'h0002, ok, acc);
        wait_res0(ok, rcyc);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL t3_res_timeout: got timeout want res_valid"); end
        e = q0.pop_front();
        i0.cmd_a = 16'hAAAA; i0.cmd_b = 16'h5555; i0.cmd_op = 16'h0003; i0.cmd_valid = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++; if ({i0.res_valid, i0.cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL t3_hold_flags: got %b want 10", {i0.res_valid, i0.cmd_ready}); end
            n_chk++; if ({i0.res_flags, i0.res_c} !== e || i0.res_c !== 16'h0204) begin n_fail++; $display("FAIL t3_hold_res: got %h want %h", {i0.res_flags, i0.res_c}, e); end
            n_chk++; if (i0.alu_a !== 16'h1234 || i0.alu_op !== 16'h0002) begin n_fail++; $display("FAIL t3_alu_hold: got %h/%h want 1234/0002", i0.alu_a, i0.alu_op); end
        end
        i0.cmd_valid = 0;
        i0.res_ready = 1;
        step();
        i0.res_ready = 0;
        step();
        n_chk++; if (i0.ops_done !== 16'd2) begin n_fail++; $display("FAIL t3_ops_done: got %0d want 2", i0.ops_done); end
        n_chk++; if ({i0.res_valid, i0.busy} !== 2'b00) begin n_fail++; $display("FAIL t3_after: got %b want 00", {i0.res_valid, i0.busy}); end
        n_chk++; if (i0.alu_a !== 16'h1234) begin n_fail++; $display("FAIL t3_no_capture: got %h want 1234", i0.alu_a); end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        int a1, a2, got;
        logic [19:0] e, want;
        logic [15:0] base;
        base = i0.ops_done;
        got = 0;
        i0.res_ready = 1;
        fork
            begin
                send0(16'hFFFF, 16'h0001, 16'h0000, ok1, a1);
                send0(16'h0003, 16'h0004, 16'h0000, ok2, a2);
            end
            begin
                for (int i = 0; i < 40 && got < 2; i++) begin
                    if (i0.res_valid) begin
                        e = q0.pop_front();
                        want = (got == 0) ? 20'h30000 : 20'h00007;
                        n_chk++; if ({i0.res_flags, i0.res_c} !== e) begin n_fail++; $display("FAIL t4_scoreboard%0d: got %h want %h", got, {i0.res_flags, i0.res_c}, e); end
                        n_chk++; if ({i0.res_flags, i0.res_c} !== want) begin n_fail++; $display("FAIL t4_order%0d: got %h want %h", got, {i0.res_flags, i0.res_c}, want); end
                        got++;
                    end
                    step();
                end
            end
        join
        i0.res_ready = 0;
        n_chk++; if (!ok1 || !ok2 || got != 2) begin n_fail++; $display("FAIL t4_progress: got %0d results want 2", got); end
        n_chk++; if (i0.ops_done !== base + 16'd2) begin n_fail++; $display("FAIL t4_ops_done: got %0d want %0d", i0.ops_done, base + 16'd2); end
        n_chk++; if (q0.size() != 0) begin n_fail++; $display("FAIL t4_queue: got %0d left want 0", q0.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int acc, rcyc;
        send0(16'h0001, 16'h0002, 16'h0000, ok, acc);
        n_chk++; if (i0.busy !== 1'b1) begin n_fail++; $display("FAIL t5_in_wait: got %b want 1", i0.busy); end
        reset0 = 0;
        #1;
        n_chk++; if ({i0.res_valid, i0.busy, i0.cmd_ready} !== 3'b000) begin n_fail++; $display("FAIL t5_async: got %b want 000", {i0.res_valid, i0.busy, i0.cmd_ready}); end
        n_chk++; if (i0.ops_done !== 16'h0 || i0.alu_a !== 16'h0) begin n_fail++; $display("FAIL t5_async_clr: got %h/%h want 0/0", i0.ops_done, i0.alu_a); end
        q0.delete();
        step();
        step();
        reset0 = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++; if (i0.res_valid !== 1'b0) begin n_fail++; $display("FAIL t5_no_result: got %b want 0", i0.res_valid); end
        end
        n_chk++; if ({i0.cmd_ready, i0.busy} !== 2'b10 || i0.ops_done !== 16'h0) begin n_fail++; $display("FAIL t5_idle: got %b/%0d want 10/0", {i0.cmd_ready, i0.busy}, i0.ops_done); end
        // Reset while a result is waiting in DONE.
        send0(16'h0010, 16'h0020, 16'h0003, ok, acc);
        wait_res0(ok, rcyc);
        reset0 = 0;
        #1;
        n_chk++; if (!ok || i0.res_valid !== 1'b0 || i0.res_c !== 16'h0) begin n_fail++; $display("FAIL t5_done_reset: got %b/%h want 0/0000", i0.res_valid, i0.res_c); end
        q0.delete();
        step();
        reset0 = 1;
        step();
    endtask

    task automatic test_wrap_comb();
        logic [19:0] e;
        logic [15:0] a, b, op;
        i1.res_ready = 1;
        for (int k = 0; k < 16; k++) begin
            a = 16'(k * 4099);
            b = 16'(k * 3 + 1);
            op = 16'(k % 4);
            n_chk++; if (i1.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL t6_ready%0d: got %b want 1", k, i1.cmd_ready); end
            i1.cmd_a = a; i1.cmd_b = b; i1.cmd_op = op; i1.cmd_valid = 1;
            step();
            q1.push_back(alu_fn(a, b, op));
            i1.cmd_valid = 0;
            step();
            n_chk++; if (i1.res_valid !== 1'b1) begin n_fail++; $display("FAIL t6_latency%0d: got %b want 1", k, i1.res_valid); end
            e = q1.pop_front();
            n_chk++; if ({i1.res_flags, i1.res_c} !== e) begin n_fail++; $display("FAIL t6_res%0d: got %h want %h", k, {i1.res_flags, i1.res_c}, e); end
            step();
            n_chk++; if (i1.ops_done !== 4'(k + 1)) begin n_fail++; $display("FAIL t6_ops_done%0d: got %0d want %0d", k, i1.ops_done, 4'(k + 1)); end
        end
        n_chk++; if (i1.ops_done !== 4'd0) begin n_fail++; $display("FAIL t6_wrap: got %0d want 0", i1.ops_done); end
        i1.res_ready = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap_comb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
